// File: rtl/axi_wr_req_pack.sv
// axi_wr_req_pack: collects one AXI write burst (header plus up to
// MAX_BURST_LEN data beats) into a single wide request for a write master.
// One burst buffer only: a new command is taken only after the previous
// packed request has been handed off.
//
// Handshakes: every channel transfers on a cycle where valid and ready are
// both high at the rising clock edge. A valid, once raised, is held with
// stable payload until accepted. Readies here are pure functions of state.
module axi_wr_req_pack #(
    parameter  int MAX_BURST_LEN   = 8,
    localparam int AXI_ID_WIDTH    = 4,
    localparam int AXI_ADDR_WIDTH  = 32,
    localparam int AXI_LEN_WIDTH   = 8,
    localparam int AXI_SIZE_WIDTH  = 3,
    localparam int AXI_BURST_WIDTH = 2,
    localparam int AXI_DATA_WIDTH  = 32
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic [AXI_ID_WIDTH-1:0]                   cmd_id,
    input  logic [AXI_ADDR_WIDTH-1:0]                 cmd_addr,
    input  logic [AXI_LEN_WIDTH-1:0]                  cmd_len,
    input  logic [AXI_SIZE_WIDTH-1:0]                 cmd_size,
    input  logic [AXI_BURST_WIDTH-1:0]                cmd_burst,
    input  logic                                      beat_valid,
    output logic                                      beat_ready,
    input  logic [AXI_DATA_WIDTH-1:0]                 beat_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]               beat_strb,
    input  logic                                      beat_last,
    output logic                                      user_req_valid,
    input  logic                                      user_req_ready,
    output logic [AXI_ID_WIDTH-1:0]                   user_req_id,
    output logic [AXI_ADDR_WIDTH-1:0]                 user_req_addr,
    output logic [AXI_LEN_WIDTH-1:0]                  user_req_len,
    output logic [AXI_SIZE_WIDTH-1:0]                 user_req_size,
    output logic [AXI_BURST_WIDTH-1:0]                user_req_burst,
    output logic [MAX_BURST_LEN*AXI_DATA_WIDTH-1:0]   user_req_wdata,
    output logic [MAX_BURST_LEN*AXI_DATA_WIDTH/8-1:0] user_req_wstrb,
    output logic                                      pack_err,
    output logic [1:0]                                dbg_state
);

    localparam int CNT_W = $clog2(MAX_BURST_LEN + 1);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam logic [AXI_LEN_WIDTH-1:0] MAX_LEN = AXI_LEN_WIDTH'(MAX_BURST_LEN - 1);
    localparam logic [AXI_SIZE_WIDTH-1:0] AXI_SIZE_1_BYTE = '0;
    localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_INCR = AXI_BURST_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] len_cnt;
    logic             cmd_fire;
    logic             beat_fire;
    logic             beat_end;
    logic             len_over;

    assign cmd_ready = (state == IDLE);
    assign beat_ready = (state == FILL);
    assign cmd_fire = cmd_valid && cmd_ready;
    assign beat_fire = beat_valid && beat_ready;
    assign len_over = (cmd_len > MAX_LEN);
    // Stored len is already clamped, so it always fits the beat counter.
    assign len_cnt = CNT_W'(user_req_len);
    // A burst closes on its final expected beat or on an early last.
    assign beat_end = beat_fire && ((beat_cnt == len_cnt) || beat_last);
    assign dbg_state = state;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_fire) state_nxt = FILL;
            FILL:    if (beat_end) state_nxt = ISSUE;
            ISSUE:   if (user_req_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered request valid, tracking the ISSUE state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            user_req_valid <= 1'b0;
        end else begin
            user_req_valid <= (state_nxt == ISSUE);
        end
    end

    // Header capture, slot clearing and beat packing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            user_req_id    <= '0;
            user_req_addr  <= '0;
            user_req_len   <= '0;
            user_req_size  <= AXI_SIZE_1_BYTE;
            user_req_burst <= AXI_BURST_INCR;
            user_req_wdata <= '0;
            user_req_wstrb <= '0;
            beat_cnt       <= '0;
        end else if (cmd_fire) begin
            user_req_id    <= cmd_id;
            user_req_addr  <= cmd_addr;
            user_req_len   <= len_over ? MAX_LEN : cmd_len;
            user_req_size  <= cmd_size;
            user_req_burst <= cmd_burst;
            user_req_wdata <= '0;
            user_req_wstrb <= '0;
            beat_cnt       <= '0;
        end else if (beat_fire) begin
            user_req_wdata[int'(beat_cnt)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= beat_data;
            user_req_wstrb[int'(beat_cnt)*STRB_W +: STRB_W] <= beat_strb;
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

    // Sticky error: oversize command, or a beat whose last flag disagrees
    // with its position (missing on the final beat, or set early).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_err <= 1'b0;
        end else if ((cmd_fire && len_over) ||
                     (beat_fire && ((beat_cnt == len_cnt) != beat_last))) begin
            pack_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_wr_req_pack.sv
// Bench for axi_wr_req_pack: directed bursts followed by random bursts,
// each packed request predicted from the burst it was built from.
module tb_axi_wr_req_pack;

    localparam int EXP_W = 1 + 4 + 32 + 8 + 3 + 2 + 32 + 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_id = '0;
    logic [31:0]  cmd_addr = '0;
    logic [7:0]   cmd_len = '0;
    logic [2:0]   cmd_size = '0;
    logic [1:0]   cmd_burst = '0;
    logic         beat_valid = 1'b0;
    logic         beat_ready;
    logic [31:0]  beat_data = '0;
    logic [3:0]   beat_strb = '0;
    logic         beat_last = 1'b0;
    logic         user_req_valid;
    logic         user_req_ready = 1'b0;
    logic [3:0]   user_req_id;
    logic [31:0]  user_req_addr;
    logic [7:0]   user_req_len;
    logic [2:0]   user_req_size;
    logic [1:0]   user_req_burst;
    logic [255:0] user_req_wdata;
    logic [31:0]  user_req_wstrb;
    logic         pack_err;
    logic [1:0]   dbg_state;

    axi_wr_req_pack #(.MAX_BURST_LEN(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .cmd_burst(cmd_burst),
        .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data),
        .beat_strb(beat_strb), .beat_last(beat_last),
        .user_req_valid(user_req_valid), .user_req_ready(user_req_ready),
        .user_req_id(user_req_id), .user_req_addr(user_req_addr),
        .user_req_len(user_req_len), .user_req_size(user_req_size),
        .user_req_burst(user_req_burst), .user_req_wdata(user_req_wdata),
        .user_req_wstrb(user_req_wstrb), .pack_err(pack_err),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    logic             model_err = 1'b0;
    int               n_total = 0;
    int               n_pass = 0;
    int               hs_cyc = 0;
    bit               rdy_rand = 1'b0;
    bit               rdy_force = 1'b1;

    wire [EXP_W-1:0] dut_vec = {pack_err, user_req_id, user_req_addr, user_req_len,
                                user_req_size, user_req_burst, user_req_wstrb,
                                user_req_wdata};

    task automatic chk(input string name, input logic [EXP_W-1:0] act,
                       input logic [EXP_W-1:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Write-master ready: random or forced, changed just after each edge.
    always @(posedge clk) begin
        #1;
        user_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
    end

    // Compare process: every cycle a request is offered it must match the
    // oldest predicted request and both input channels must be closed.
    always @(negedge clk) begin
        if (!rst && user_req_valid) begin
            if (exp_q.size() == 0) begin
                timeout("unexpected_request");
            end else begin
                chk("request", dut_vec, exp_q[0]);
                chk("readies_in_issue", {cmd_ready, beat_ready}, 2'b00);
                if (user_req_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks (entered just after an edge) ----------------
    task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
        int n = 0;
        cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr; cmd_len = len;
        cmd_size = size; cmd_burst = burst;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) timeout("cmd_ready");
        @(posedge clk);
        hs_cyc = cyc;
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        beat_valid = 1'b1; beat_data = d; beat_strb = s; beat_last = l;
        while (!beat_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) timeout("beat_ready");
        @(posedge clk); #1;
        beat_valid = 1'b0;
    endtask

    // Predict one burst from the rules, queue it, then drive it. p is the
    // index of the beat carrying last (p > clamped len means no last at all).
    // base >= 0 selects data base+i with full strobes.
    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr,
                             input logic [7:0] len, input int p, input int base,
                             input bit gaps);
        logic [31:0]  d[8];
        logic [3:0]   s[8];
        logic [255:0] ew = '0;
        logic [31:0]  es = '0;
        logic [2:0]   size = 3'($urandom_range(0, 7));
        logic [1:0]   burst = 2'($urandom_range(0, 2));
        int           eff = (len > 8'd7) ? 7 : int'(len);
        int           n = (p < eff) ? p + 1 : eff + 1;
        logic         err = model_err | (len > 8'd7) | (p != eff);
        for (int i = 0; i < n; i++) begin
            d[i] = (base >= 0) ? 32'(base + i) : $urandom;
            s[i] = (base >= 0) ? 4'hF : 4'($urandom_range(0, 15));
            ew[i*32 +: 32] = d[i];
            es[i*4 +: 4] = s[i];
        end
        exp_q.push_back({err, id, addr, 8'(eff), size, burst, es, ew});
        model_err = err;
        send_cmd(id, addr, len, size, burst);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_beat(d[i], s[i], 1'(i == p));
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!user_req_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) timeout(name);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 500) timeout("drain");
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1;
        // Reset values while rst is held.
        chk("rst_valid", user_req_valid, 0);
        chk("rst_hdr", {user_req_id, user_req_addr, user_req_len, user_req_size,
                        user_req_burst}, {4'h0, 32'h0, 8'h0, 3'd0, 2'd1});
        chk("rst_data", {user_req_wstrb, user_req_wdata}, '0);
        chk("rst_err", pack_err, 0);
        rst = 1'b0;
        chk("cmd_ready_after_rst", cmd_ready, 1);
        chk("dbg_state_idle", dbg_state, 0);

        // Beats offered while idle are refused and never consumed.
        beat_valid = 1'b1; beat_data = 32'hDEAD_BEEF; beat_strb = 4'hF; beat_last = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_beat_ready", beat_ready, 0);
        end
        beat_valid = 1'b0; beat_last = 1'b0;

        // Normal burst, held un-accepted for a first look.
        rdy_force = 1'b0;
        run_burst(4'h1, 32'h100, 8'd3, 3, 'hA0, 1'b0);
        wait_valid("norm_valid");
        chk("norm_len", user_req_len, 3);
        chk("norm_addr", user_req_addr, 32'h100);
        chk("norm_wdata", user_req_wdata, 256'h000000A3_000000A2_000000A1_000000A0);
        chk("norm_wstrb", user_req_wstrb, 32'h0000FFFF);
        chk("norm_err", pack_err, 0);
        rdy_force = 1'b1;
        drain();

        // Backpressure: five refused cycles with everything held.
        rdy_force = 1'b0;
        run_burst(4'h2, 32'h200, 8'd2, 2, -1, 1'b0);
        wait_valid("bp_valid");
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold", {user_req_valid, cmd_ready, beat_ready}, 3'b100);
        end
        rdy_force = 1'b1;
        drain();

        // Early last on beat 1 of a 6-beat burst.
        rdy_force = 1'b0;
        run_burst(4'h3, 32'h300, 8'd5, 1, 'hB0, 1'b0);
        wait_valid("early_valid");
        chk("early_len", user_req_len, 5);
        chk("early_wstrb", user_req_wstrb, 32'h000000FF);
        chk("early_err", pack_err, 1);
        rdy_force = 1'b1;
        drain();

        // Oversize command: clamped to eight beats.
        rdy_force = 1'b0;
        run_burst(4'h4, 32'h400, 8'd15, 7, 'hC0, 1'b0);
        wait_valid("over_valid");
        chk("over_len", user_req_len, 7);
        chk("over_wstrb", user_req_wstrb, 32'hFFFFFFFF);
        chk("over_slot7", user_req_wdata[255:224], 32'hC7);
        chk("over_err", pack_err, 1);
        rdy_force = 1'b1;
        drain();

        // Reset in the middle of FILL discards the partial burst.
        send_cmd(4'h5, 32'h500, 8'd3, 3'd2, 2'd1);
        send_beat(32'h11, 4'hF, 1'b0);
        send_beat(32'h22, 4'hF, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", user_req_valid, 0);
        chk("mid_rst_hdr", {user_req_id, user_req_addr, user_req_len, user_req_size,
                            user_req_burst}, {4'h0, 32'h0, 8'h0, 3'd0, 2'd1});
        chk("mid_rst_data", {user_req_wstrb, user_req_wdata}, '0);
        chk("mid_rst_err", pack_err, 0);
        chk("mid_rst_state", dbg_state, 0);
        model_err = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        rdy_force = 1'b0;
        run_burst(4'h6, 32'h600, 8'd0, 0, 'h55, 1'b0);
        wait_valid("post_rst_valid");
        chk("post_rst_wdata", user_req_wdata, 256'h55);
        chk("post_rst_wstrb", user_req_wstrb, 32'h0000000F);
        chk("post_rst_err", pack_err, 0);
        rdy_force = 1'b1;
        drain();

        // Back-to-back single-beat bursts: one command every three cycles.
        begin
            int prev;
            for (int k = 0; k < 4; k++) begin
                run_burst(4'(8 + k), 32'h1000 + 32'(k * 4), 8'd0, 0, -1, 1'b0);
                if (k > 0) chk("b2b_spacing", 32'(hs_cyc - prev), 3);
                prev = hs_cyc;
            end
            drain();
        end

        // Random bursts with random beat gaps and write-master stalls.
        rdy_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            logic [7:0] len = 8'($urandom_range(0, 10));
            int eff = (len > 8'd7) ? 7 : int'(len);
            run_burst(4'($urandom_range(0, 15)), $urandom, len,
                      $urandom_range(0, eff + 1), -1, 1'b1);
        end
        drain();
        rdy_rand = 1'b0;
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
